// File: rtl/mcu_dma_engine_pkg.sv
// Shared definitions for the MCU DMA engine: bus widths, default sizes,
// Wishbone tag values and the controller state encoding.
package mcu_dma_engine_pkg;

  // Width of every address and data word on the memory and Wishbone sides.
  localparam int WB_WIDTH       = 16;
  // Default number of destination cores and default request-queue depth.
  localparam int MAX_CORES      = 4;
  localparam int MCU_FIFO_DEPTH = 4;

  // Default words per block for code and data destinations.
  localparam int CODE_BEATS_DEFAULT = 2;
  localparam int DATA_BEATS_DEFAULT = 3;

  // Values driven on TAG_O to tell the cores what kind of write this is.
  localparam logic [1:0] TAG_NULL                     = 2'b00;
  localparam logic [1:0] TAG_INSTRUCTION_ADDRESS_TYPE = 2'b01;
  localparam logic [1:0] TAG_DATA_ADDRESS_TYPE        = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ABORT = 3'd6
  } dma_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mcu_dma_engine_sync_fifo.sv
// Synchronous request queue with a combinational head output. A push and a
// pop in the same cycle both succeed even when the queue is full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iPush,
  input  logic             iPop,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oData,
  output logic             oFull,
  output logic             oEmpty,
  output logic             oPushAccepted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign oFull   = (count_q == DEPTH_C);
  assign oEmpty  = (count_q == '0);
  assign pop_ok  = iPop && !oEmpty;
  // A slot freed by a same-cycle pop can take the incoming word.
  assign push_ok = iPush && (!oFull || pop_ok);
  assign oPushAccepted = push_ok;
  assign oData   = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge Clock) begin
    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, and skipping the reset keeps the
    // array mappable to plain RAM.
    if (push_ok) mem_q[wr_ptr_q] <= iData;
  end

endmodule

// File: rtl/mcu_dma_engine.sv
// MCU DMA engine: queues copy requests, reads words from memory one at a
// time and writes them to one or more cores over a Wishbone master port.
module mcu_dma_engine
  import mcu_dma_engine_pkg::*;
#(
  parameter int CORE_COUNT  = MAX_CORES,
  parameter int FIFO_DEPTH  = MCU_FIFO_DEPTH,
  parameter int CODE_BEATS  = CODE_BEATS_DEFAULT,
  parameter int DATA_BEATS  = DATA_BEATS_DEFAULT,
  parameter int LEN_W       = 11,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  Clock,
  input  logic                  Reset,
  // Request interface
  input  logic                  iReqValid,
  input  logic [WB_WIDTH-1:0]   iReqSrc,
  input  logic [WB_WIDTH-1:0]   iReqDst,
  input  logic [LEN_W-1:0]      iReqLen,
  input  logic [CORE_COUNT-1:0] iReqMask,
  input  logic                  iReqType,
  // Status
  output logic                  oFifoFull,
  output logic                  oFifoEmpty,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oError,
  output logic                  oOverflow,
  // Memory read port
  output logic                  oMEM_ReadRequest,
  output logic [WB_WIDTH-1:0]   oMEM_ReadAddress,
  input  logic [WB_WIDTH-1:0]   iMEM_ReadData,
  input  logic                  iMEM_DataAvailable,
  // Wishbone master
  output logic [WB_WIDTH-1:0]   DAT_O,
  output logic [WB_WIDTH-1:0]   ADR_O,
  output logic                  STB_O,
  output logic                  CYC_O,
  output logic                  MST_O,
  output logic [CORE_COUNT-1:0] WE_O,
  output logic [1:0]            TAG_O,
  input  logic                  ACK_I
);

  localparam int REQ_W     = 2 * WB_WIDTH + LEN_W + CORE_COUNT + 1;
  localparam int MAX_BEATS = max_int(CODE_BEATS, DATA_BEATS);
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int STALL_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(ACK_TIMEOUT - 1);
  localparam logic [BEAT_W-1:0]  CODE_LAST  = BEAT_W'(CODE_BEATS - 1);
  localparam logic [BEAT_W-1:0]  DATA_LAST  = BEAT_W'(DATA_BEATS - 1);

  dma_state_e state_q, state_d;

  logic [WB_WIDTH-1:0]   src_q, src_d;
  logic [WB_WIDTH-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CORE_COUNT-1:0] mask_q, mask_d;
  logic                  type_q, type_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [LEN_W-1:0]      block_q, block_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic [WB_WIDTH-1:0]   dat_q, dat_d;
  logic                  overflow_q;

  // Request queue
  logic [REQ_W-1:0]      fifo_wdata, fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_pop, fifo_push_ok;
  logic [WB_WIDTH-1:0]   head_src, head_dst;
  logic [LEN_W-1:0]      head_len;
  logic [CORE_COUNT-1:0] head_mask;
  logic                  head_type;
  logic [BEAT_W-1:0]     beat_last;
  logic [LEN_W-1:0]      block_inc;

  assign fifo_wdata = {iReqType, iReqMask, iReqLen, iReqDst, iReqSrc};
  assign {head_type, head_mask, head_len, head_dst, head_src} = fifo_rdata;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .Clock         (Clock),
    .Reset         (Reset),
    .iPush         (iReqValid),
    .iPop          (fifo_pop),
    .iData         (fifo_wdata),
    .oData         (fifo_rdata),
    .oFull         (fifo_full),
    .oEmpty        (fifo_empty),
    .oPushAccepted (fifo_push_ok)
  );

  assign beat_last = type_q ? DATA_LAST : CODE_LAST;
  assign block_inc = block_q + LEN_W'(1);

  // Next-state and working-register update for the transfer controller.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    mask_d   = mask_q;
    type_d   = type_q;
    beat_d   = beat_q;
    block_d  = block_q;
    stall_d  = stall_q;
    dat_d    = dat_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        src_d    = head_src;
        dst_d    = head_dst;
        len_d    = head_len;
        mask_d   = head_mask;
        type_d   = head_type;
        beat_d   = '0;
        block_d  = '0;
        stall_d  = '0;
        // Nothing to copy, or nobody to copy to: reject the request.
        state_d  = (head_len == '0 || head_mask == '0) ? ST_ABORT : ST_READ;
      end
      ST_READ: begin
        stall_d = '0;
        if (iMEM_DataAvailable) begin
          dat_d   = iMEM_ReadData;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (ACK_I) begin
          src_d   = src_q + WB_WIDTH'(1);
          beat_d  = beat_q + BEAT_W'(1);
          stall_d = '0;
          state_d = (beat_q == beat_last) ? ST_NEXT : ST_READ;
        end else if (stall_q == STALL_LAST) begin
          // The core never answered: give up on this request only.
          state_d = ST_ABORT;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      ST_NEXT: begin
        beat_d  = '0;
        dst_d   = dst_q + WB_WIDTH'(1);
        block_d = block_inc;
        state_d = (block_inc == len_q) ? ST_DONE : ST_READ;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and working registers; reset abandons any transfer in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      mask_q     <= '0;
      type_q     <= 1'b0;
      beat_q     <= '0;
      block_q    <= '0;
      stall_q    <= '0;
      dat_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      mask_q     <= mask_d;
      type_q     <= type_d;
      beat_q     <= beat_d;
      block_q    <= block_d;
      stall_q    <= stall_d;
      dat_q      <= dat_d;
      // A push the queue could not take is reported one cycle later.
      overflow_q <= iReqValid && !fifo_push_ok;
    end
  end

  // Output decode from the controller state.
  always_comb begin
    oMEM_ReadRequest = (state_q == ST_READ);
    oMEM_ReadAddress = src_q;
    DAT_O            = dat_q;
    ADR_O            = dst_q;
    STB_O            = (state_q == ST_WRITE);
    CYC_O            = (state_q == ST_READ) || (state_q == ST_WRITE) ||
                       (state_q == ST_NEXT);
    MST_O            = CYC_O;
    WE_O             = (state_q == ST_WRITE) ? mask_q : '0;
    TAG_O            = TAG_NULL;
    if (state_q == ST_WRITE)
      TAG_O = type_q ? TAG_DATA_ADDRESS_TYPE : TAG_INSTRUCTION_ADDRESS_TYPE;
    oBusy            = (state_q != ST_IDLE);
    oDone            = (state_q == ST_DONE);
    oError           = (state_q == ST_ABORT);
    oOverflow        = overflow_q;
    oFifoFull        = fifo_full;
    oFifoEmpty       = fifo_empty;
  end

endmodule

// File: tb/tb_mcu_dma_engine.sv
// Directed bench for mcu_dma_engine: memory and Wishbone slave responders,
// a beat log, and hand-computed expectations for each scenario.
module tb_mcu_dma_engine;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iReqValid;
  logic [15:0] iReqSrc, iReqDst;
  logic [10:0] iReqLen;
  logic [3:0]  iReqMask;
  logic        iReqType;
  logic        oFifoFull, oFifoEmpty, oBusy, oDone, oError, oOverflow;
  logic        oMEM_ReadRequest;
  logic [15:0] oMEM_ReadAddress;
  logic [15:0] iMEM_ReadData;
  logic        iMEM_DataAvailable;
  logic [15:0] DAT_O, ADR_O;
  logic        STB_O, CYC_O, MST_O;
  logic [3:0]  WE_O;
  logic [1:0]  TAG_O;
  logic        ACK_I;

  mcu_dma_engine dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .iReqValid          (iReqValid),
    .iReqSrc            (iReqSrc),
    .iReqDst            (iReqDst),
    .iReqLen            (iReqLen),
    .iReqMask           (iReqMask),
    .iReqType           (iReqType),
    .oFifoFull          (oFifoFull),
    .oFifoEmpty         (oFifoEmpty),
    .oBusy              (oBusy),
    .oDone              (oDone),
    .oError             (oError),
    .oOverflow          (oOverflow),
    .oMEM_ReadRequest   (oMEM_ReadRequest),
    .oMEM_ReadAddress   (oMEM_ReadAddress),
    .iMEM_ReadData      (iMEM_ReadData),
    .iMEM_DataAvailable (iMEM_DataAvailable),
    .DAT_O              (DAT_O),
    .ADR_O              (ADR_O),
    .STB_O              (STB_O),
    .CYC_O              (CYC_O),
    .MST_O              (MST_O),
    .WE_O               (WE_O),
    .TAG_O              (TAG_O),
    .ACK_I              (ACK_I)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory contents seen by the engine: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3C3;
  endfunction

  function automatic logic [63:0] outs();
    return {oFifoFull, oFifoEmpty, oBusy, oDone, oError, oOverflow,
            oMEM_ReadRequest, oMEM_ReadAddress, DAT_O, ADR_O,
            STB_O, CYC_O, MST_O, WE_O, TAG_O};
  endfunction

  localparam logic [63:0] RESET_OUTS = {1'b0, 1'b1, 62'd0};

  // Responder knobs
  int mem_lat = 0;
  int ack_lat = 0;
  bit ack_never = 0;
  bit check_stable = 0;

  // Beat log: one entry per acknowledged Wishbone write
  logic [15:0] log_adr[$];
  logic [15:0] log_dat[$];
  logic [3:0]  log_we[$];
  logic [1:0]  log_tag[$];

  // Memory responder: answers a read request after mem_lat waiting cycles.
  int mem_cnt = 0;
  always @(negedge Clock) begin
    if (oMEM_ReadRequest) begin
      if (mem_cnt >= mem_lat) begin
        iMEM_DataAvailable = 1'b1;
        iMEM_ReadData      = mem_word(oMEM_ReadAddress);
        mem_cnt            = 0;
      end else begin
        iMEM_DataAvailable = 1'b0;
        iMEM_ReadData      = 16'hDEAD;
        mem_cnt++;
      end
    end else begin
      iMEM_DataAvailable = 1'b0;
      iMEM_ReadData      = 16'hDEAD;
      mem_cnt            = 0;
    end
  end

  // Wishbone slave: acks a strobe after ack_lat stall cycles, logs the beat,
  // and optionally checks that the bus holds still during the stall.
  int ack_cnt = 0;
  logic [37:0] hold_bus, cur_bus;
  always @(negedge Clock) begin
    if (STB_O) begin
      cur_bus = {ADR_O, DAT_O, WE_O, TAG_O};
      if (ack_cnt == 0) hold_bus = cur_bus;
      else if (check_stable) check("stall_hold", cur_bus, hold_bus);
      if (!ack_never && ack_cnt >= ack_lat) begin
        log_adr.push_back(ADR_O);
        log_dat.push_back(DAT_O);
        log_we.push_back(WE_O);
        log_tag.push_back(TAG_O);
        ACK_I   = 1'b1;
        ack_cnt = 0;
      end else begin
        ACK_I = 1'b0;
        ack_cnt++;
      end
    end else begin
      ACK_I   = 1'b0;
      ack_cnt = 0;
    end
  end

  // Event counters, sampled just after each rising edge.
  int cyc = 0, done_cnt = 0, err_cnt = 0, ovf_cnt = 0, stb_rises = 0;
  int stb_rise_cyc = 0, err_cyc = 0;
  bit stb_prev = 0;
  always @(posedge Clock) begin
    #1;
    cyc++;
    if (oDone) done_cnt++;
    if (oError) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (oOverflow) ovf_cnt++;
    if (STB_O && !stb_prev) begin
      stb_rises++;
      stb_rise_cyc = cyc;
    end
    stb_prev = STB_O;
  end

  task automatic push(input logic [15:0] s, input logic [15:0] d, input logic [10:0] l,
                      input logic [3:0] m, input logic t);
    iReqSrc   = s;
    iReqDst   = d;
    iReqLen   = l;
    iReqMask  = m;
    iReqType  = t;
    iReqValid = 1'b1;
    @(negedge Clock);
    iReqValid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge Clock);
      k++;
    end
    check(tag, done_cnt, target);
  endtask

  task automatic wait_stb(input string tag);
    int k = 0;
    while (!STB_O && k < 100) begin
      @(negedge Clock);
      k++;
    end
    check(tag, STB_O, 1'b1);
  endtask

  task automatic clear_log();
    log_adr.delete();
    log_dat.delete();
    log_we.delete();
    log_tag.delete();
  endtask

  task automatic check_beat(input string tag, input int i, input logic [15:0] adr,
                            input logic [15:0] dat, input logic [3:0] we,
                            input logic [1:0] tg);
    if (i < log_adr.size()) begin
      check($sformatf("%s_adr%0d", tag, i), log_adr[i], adr);
      check($sformatf("%s_dat%0d", tag, i), log_dat[i], dat);
      check($sformatf("%s_we%0d", tag, i),  log_we[i],  we);
      check($sformatf("%s_tag%0d", tag, i), log_tag[i], tg);
    end else begin
      check($sformatf("%s_missing%0d", tag, i), 0, 1);
    end
  endtask

  int d0, e0, o0, s0;

  initial begin
    Reset = 1'b1;
    iReqValid = 1'b0; iReqSrc = '0; iReqDst = '0; iReqLen = '0;
    iReqMask = '0; iReqType = 1'b0;
    iMEM_DataAvailable = 1'b0; iMEM_ReadData = '0; ACK_I = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_outs", outs(), RESET_OUTS);
    Reset = 1'b0;
    @(negedge Clock);
    check("idle_outs", outs(), RESET_OUTS);

    // Code request, two blocks of two words each
    clear_log();
    d0 = done_cnt;
    push(16'h0100, 16'h0010, 11'd2, 4'b0001, 1'b0);
    wait_done("t1_wait", d0 + 1, 200);
    repeat (4) @(negedge Clock);
    check("t1_beats", log_adr.size(), 4);
    for (int i = 0; i < 4; i++)
      check_beat("t1", i, 16'h0010 + 16'(i / 2), mem_word(16'h0100 + 16'(i)), 4'b0001, 2'b01);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_idle", oBusy, 1'b0);

    // Data request, broadcast, slow memory and slow ACK
    clear_log();
    d0 = done_cnt;
    mem_lat = 2; ack_lat = 5; check_stable = 1;
    push(16'h0300, 16'h0060, 11'd1, 4'b1111, 1'b1);
    wait_done("t2_wait", d0 + 1, 200);
    check_stable = 0; mem_lat = 0; ack_lat = 0;
    check("t2_beats", log_adr.size(), 3);
    for (int i = 0; i < 3; i++)
      check_beat("t2", i, 16'h0060, mem_word(16'h0300 + 16'(i)), 4'b1111, 2'b10);

    // Fill the queue behind a stalled transfer, one request too many
    clear_log();
    repeat (3) @(negedge Clock);
    d0 = done_cnt; o0 = ovf_cnt;
    ack_lat = 40;
    push(16'h0200, 16'h0020, 11'd1, 4'b0001, 1'b0);
    wait_stb("t3_stall");
    for (int j = 0; j < 5; j++)
      push(16'h0400 + 16'(16 * j), 16'h0030 + 16'(j), 11'd1, 4'b0010, 1'b0);
    check("t3_ovf_pulse", oOverflow, 1'b1);
    check("t3_full", oFifoFull, 1'b1);
    @(negedge Clock);
    check("t3_ovf_drop", oOverflow, 1'b0);
    ack_lat = 0;
    wait_done("t3_wait", d0 + 5, 600);
    repeat (10) @(negedge Clock);
    check("t3_done_cnt", done_cnt - d0, 5);
    check("t3_ovf_cnt", ovf_cnt - o0, 1);
    check("t3_beats", log_adr.size(), 10);
    check_beat("t3", 0, 16'h0020, mem_word(16'h0200), 4'b0001, 2'b01);
    check_beat("t3", 1, 16'h0020, mem_word(16'h0201), 4'b0001, 2'b01);
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < 2; b++)
        check_beat("t3", 2 + 2 * j + b, 16'h0030 + 16'(j),
                   mem_word(16'h0400 + 16'(16 * j + b)), 4'b0010, 2'b01);

    // ACK never comes: timeout abort, then the next request runs
    clear_log();
    d0 = done_cnt; e0 = err_cnt;
    ack_never = 1;
    push(16'h0500, 16'h0040, 11'd1, 4'b0001, 1'b0);
    push(16'h0600, 16'h0050, 11'd1, 4'b0100, 1'b0);
    begin
      int k = 0;
      while (err_cnt == e0 && k < 400) begin
        @(negedge Clock);
        k++;
      end
    end
    ack_never = 0;
    check("t4_err", err_cnt - e0, 1);
    check("t4_timeout_cycles", err_cyc - stb_rise_cyc, 255);
    wait_done("t4_next_wait", d0 + 1, 100);
    check("t4_beats", log_adr.size(), 2);
    check_beat("t4", 0, 16'h0050, mem_word(16'h0600), 4'b0100, 2'b01);
    check_beat("t4", 1, 16'h0050, mem_word(16'h0601), 4'b0100, 2'b01);

    // Zero length and empty mask are rejected without touching the bus
    repeat (3) @(negedge Clock);
    e0 = err_cnt; s0 = stb_rises;
    push(16'h0700, 16'h0070, 11'd0, 4'b0001, 1'b0);
    repeat (10) @(negedge Clock);
    check("t5_len0_err", err_cnt - e0, 1);
    push(16'h0710, 16'h0071, 11'd1, 4'b0000, 1'b1);
    repeat (10) @(negedge Clock);
    check("t5_mask0_err", err_cnt - e0, 2);
    check("t5_no_stb", stb_rises - s0, 0);
    check("t5_idle", oBusy, 1'b0);

    // Reset in the middle of a write with another request queued
    ack_never = 1;
    e0 = err_cnt;
    push(16'h0800, 16'h0080, 11'd2, 4'b0011, 1'b1);
    wait_stb("t6_write");
    push(16'h0900, 16'h0090, 11'd1, 4'b0001, 1'b0);
    check("t6_queued", oFifoEmpty, 1'b0);
    Reset = 1'b1;
    @(negedge Clock);
    check("t6_reset_outs", outs(), RESET_OUTS);
    Reset = 1'b0;
    ack_never = 0;
    repeat (5) @(negedge Clock);
    check("t6_no_err", err_cnt - e0, 0);
    check("t6_idle", oBusy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
